// File: rtl/tsmp_frame_filter_pkg.sv
// Shared constants and types for the TSMP ingress frame filter.
package tsmp_frame_filter_pkg;

  // Cycle markers carried in the top two bits of every frame cycle
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  // TSMP subtypes the downstream decapsulator understands
  localparam logic [7:0] ARP_ACK  = 8'h00;
  localparam logic [7:0] NMAC_CFG = 8'h02;
  localparam logic [7:0] PTP      = 8'h05;

  localparam logic [15:0] TSMP_ETHERTYPE_DEF = 16'hFF01;

  // Field positions inside a 134-bit frame cycle
  localparam int MARK_HI  = 133;
  localparam int MARK_LO  = 132;
  localparam int ETYPE_HI = 31;
  localparam int ETYPE_LO = 16;
  localparam int SUBT_HI  = 15;
  localparam int SUBT_LO  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic subtype_ok(input logic [7:0] st);
    return (st == ARP_ACK) || (st == NMAC_CFG) || (st == PTP);
  endfunction

endpackage

// File: rtl/tsmp_frame_filter_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module tsmp_frame_filter_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] ov_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count one event per enabled cycle, stopping at the top value
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ov_cnt = r_cnt;

endmodule

// File: rtl/tsmp_frame_filter.sv
// TSMP ingress filter: forwards well-formed supported TSMP frames with one
// cycle of latency and guarantees every forwarded frame is head/tail bounded.
module tsmp_frame_filter
  import tsmp_frame_filter_pkg::*;
#(
  parameter logic [15:0] TSMP_ETHERTYPE = TSMP_ETHERTYPE_DEF,
  parameter int          MAX_CYCLES     = 128,
  parameter int          CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [133:0]     iv_data,
  input  logic             i_data_wr,
  output logic [133:0]     ov_data,
  output logic             o_data_wr,
  output logic [CNT_W-1:0] ov_pass_cnt,
  output logic [CNT_W-1:0] ov_drop_cnt
);

  localparam int CYC_W = $clog2(MAX_CYCLES) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [CYC_W-1:0]   r_cyc;
  logic [CYC_W-1:0]   w_cyc_next;
  logic [CYC_W-1:0]   w_cyc_inc;
  logic [133:0]       r_data;
  logic [133:0]       w_data_next;
  logic               r_wr;
  logic               w_wr_next;
  logic               w_pass_inc;
  logic               w_drop_inc;
  logic [1:0]         w_mark;
  logic               w_head_ok;
  logic [133:0]       w_as_tail;

  assign w_mark    = iv_data[MARK_HI:MARK_LO];
  assign w_head_ok = (iv_data[ETYPE_HI:ETYPE_LO] == TSMP_ETHERTYPE) &&
                     subtype_ok(iv_data[SUBT_HI:SUBT_LO]);
  // Same cycle with its marker rewritten so downstream sees the frame close
  assign w_as_tail = {TAIL, iv_data[MARK_LO-1:0]};
  assign w_cyc_inc = r_cyc + CYC_W'(1);

  // State, cycle count and the registered output stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cyc   <= w_cyc_next;
      r_data  <= w_data_next;
      r_wr    <= w_wr_next;
    end
  end

  // Frame acceptance, truncation and tail-repair decisions
  always_comb begin
    w_state_next = r_state;
    w_cyc_next   = r_cyc;
    w_data_next  = '0;
    w_wr_next    = 1'b0;
    w_pass_inc   = 1'b0;
    w_drop_inc   = 1'b0;

    if (i_data_wr) begin
      unique case (r_state)
        ST_IDLE, ST_DROP: begin
          if (w_mark == HEAD) begin
            if (w_head_ok) begin
              w_data_next  = iv_data;
              w_wr_next    = 1'b1;
              w_cyc_next   = CYC_W'(1);
              w_state_next = ST_PASS;
            end else begin
              w_drop_inc   = 1'b1;
              w_cyc_next   = '0;
              w_state_next = ST_DROP;
            end
          end else if ((r_state == ST_DROP) && (w_mark == TAIL)) begin
            w_state_next = ST_IDLE;
          end
        end
        ST_PASS: begin
          if (w_mark == HEAD) begin
            // Previous tail never came: close it on this cycle, discard the new frame
            w_data_next  = w_as_tail;
            w_wr_next    = 1'b1;
            w_drop_inc   = 1'b1;
            w_cyc_next   = '0;
            w_state_next = ST_DROP;
          end else if (w_mark == TAIL) begin
            w_data_next  = iv_data;
            w_wr_next    = 1'b1;
            w_pass_inc   = 1'b1;
            w_state_next = ST_IDLE;
          end else if (w_cyc_inc == CYC_W'(MAX_CYCLES)) begin
            // Last permitted cycle without a tail: truncate the frame here
            w_data_next  = w_as_tail;
            w_wr_next    = 1'b1;
            w_drop_inc   = 1'b1;
            w_cyc_next   = w_cyc_inc;
            w_state_next = ST_DROP;
          end else begin
            w_data_next  = iv_data;
            w_wr_next    = 1'b1;
            w_cyc_next   = w_cyc_inc;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  tsmp_frame_filter_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_inc  (w_pass_inc),
    .ov_cnt (ov_pass_cnt)
  );

  tsmp_frame_filter_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_inc  (w_drop_inc),
    .ov_cnt (ov_drop_cnt)
  );

  assign ov_data   = r_data;
  assign o_data_wr = r_wr;

endmodule

// File: tb/tb_tsmp_frame_filter.sv
// Scoreboard bench for the TSMP ingress frame filter.
module tb_tsmp_frame_filter;
  import tsmp_frame_filter_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [133:0] din = '0;
  logic         wr  = 1'b0;

  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [15:0]  pass_cnt;
  logic [15:0]  drop_cnt;

  logic [133:0] sat_data;
  logic         sat_wr;
  logic [3:0]   sat_pass;
  logic [3:0]   sat_drop;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [133:0] exp_q[$];
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  tsmp_frame_filter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .iv_data     (din),
    .i_data_wr   (wr),
    .ov_data     (ov_data),
    .o_data_wr   (o_data_wr),
    .ov_pass_cnt (pass_cnt),
    .ov_drop_cnt (drop_cnt)
  );

  tsmp_frame_filter #(.CNT_W(4)) dut_sat (
    .i_clk       (clk),
    .i_rst       (rst),
    .iv_data     (din),
    .i_data_wr   (wr),
    .ov_data     (sat_data),
    .o_data_wr   (sat_wr),
    .ov_pass_cnt (sat_pass),
    .ov_drop_cnt (sat_drop)
  );

  task automatic check(input string tag, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [133:0] mk(input logic [1:0] m, input logic [15:0] et,
                                      input logic [7:0] st, input int idx);
    return {m, 4'hF, 64'hC0FFEE0012345678, idx[15:0], 16'hA5A5, et, st, 8'h03};
  endfunction

  function automatic logic [133:0] as_tail(input logic [133:0] d);
    return {TAIL, d[131:0]};
  endfunction

  function automatic logic [1:0] mark_of(input int i, input int n);
    if (i == 0) return HEAD;
    if (i == n - 1) return TAIL;
    return MID;
  endfunction

  // Output monitor: every written cycle must match the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_data_wr) begin
        if (exp_q.size() == 0) check("spurious_out", o_data_wr, 1'b0);
        else check("out_data", ov_data, exp_q.pop_front());
      end else begin
        check("idle_data", ov_data, '0);
      end
    end
  end

  task automatic drive(input logic [133:0] d, input logic w);
    din = d;
    wr  = w;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    logic [133:0] g;
    for (int i = 0; i < n; i++) begin
      g = {6'($urandom), $urandom, $urandom, $urandom, $urandom};
      drive(g, 1'b0);
    end
  endtask

  task automatic send(input logic [15:0] et, input logic [7:0] st, input int n, input bit fwd);
    logic [133:0] d;
    for (int i = 0; i < n; i++) begin
      d = mk(mark_of(i, n), et, st, i);
      if (fwd) exp_q.push_back(d);
      drive(d, 1'b1);
    end
  endtask

  task automatic do_reset();
    gap(2);
    check("q_drained", 134'(exp_q.size()), '0);
    rst = 1'b1;
    wr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_wr", o_data_wr, 1'b0);
    check("rst_data", ov_data, '0);
    check("rst_pass", pass_cnt, '0);
    check("rst_drop", drop_cnt, '0);
  endtask

  initial begin
    logic [133:0] d;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // T1: valid ARP ack frame passes unchanged
    do_reset();
    send(16'hFF01, ARP_ACK, 4, 1'b1);
    gap(2);
    check("t1_pass", pass_cnt, 16'd1);
    check("t1_drop", drop_cnt, 16'd0);

    // T2: foreign ethertype and unsupported subtype dropped, PTP passes
    do_reset();
    send(16'h0800, ARP_ACK, 4, 1'b0);
    send(16'hFF01, 8'h07, 3, 1'b0);
    gap(1);
    check("t2_drop", drop_cnt, 16'd2);
    send(16'hFF01, PTP, 5, 1'b1);
    gap(2);
    check("t2_pass", pass_cnt, 16'd1);
    check("t2_drop2", drop_cnt, 16'd2);

    // T3: 130-cycle frame truncated at 128 with synthesized tail
    do_reset();
    for (int i = 0; i < 130; i++) begin
      d = mk(mark_of(i, 130), 16'hFF01, NMAC_CFG, i);
      if (i < 127) exp_q.push_back(d);
      else if (i == 127) exp_q.push_back(as_tail(d));
      drive(d, 1'b1);
    end
    gap(2);
    check("t3_drop", drop_cnt, 16'd1);
    check("t3_pass0", pass_cnt, 16'd0);
    send(16'hFF01, ARP_ACK, 2, 1'b1);
    // A real tail on cycle 128, with idle gaps inside, is a normal pass
    for (int i = 0; i < 128; i++) begin
      d = mk(mark_of(i, 128), 16'hFF01, PTP, i);
      exp_q.push_back(d);
      drive(d, 1'b1);
      if (i == 60 || i == 126) gap(3);
    end
    gap(2);
    check("t3_pass", pass_cnt, 16'd2);
    check("t3_drop2", drop_cnt, 16'd1);

    // T4: missing tail, new head closes the frame and is itself discarded
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = mk((i == 0) ? HEAD : MID, 16'hFF01, NMAC_CFG, i);
      exp_q.push_back(d);
      drive(d, 1'b1);
    end
    d = mk(HEAD, 16'hFF01, ARP_ACK, 0);
    exp_q.push_back(as_tail(d));
    drive(d, 1'b1);
    drive(mk(MID, 16'hFF01, ARP_ACK, 1), 1'b1);
    drive(mk(MID, 16'hFF01, ARP_ACK, 2), 1'b1);
    drive(mk(TAIL, 16'hFF01, ARP_ACK, 3), 1'b1);
    gap(2);
    check("t4_drop", drop_cnt, 16'd1);
    check("t4_pass", pass_cnt, 16'd0);
    send(16'hFF01, PTP, 3, 1'b1);
    gap(2);
    check("t4_pass2", pass_cnt, 16'd1);

    // T5: reset in the middle of a frame, orphans ignored afterwards
    do_reset();
    send(16'hFF01, ARP_ACK, 3, 1'b1);
    send(16'h0800, ARP_ACK, 2, 1'b0);
    d = mk(HEAD, 16'hFF01, PTP, 0);
    exp_q.push_back(d);
    drive(d, 1'b1);
    d = mk(MID, 16'hFF01, PTP, 1);
    exp_q.push_back(d);
    drive(d, 1'b1);
    din = mk(MID, 16'hFF01, PTP, 2);
    wr  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_wr", o_data_wr, 1'b0);
    check("t5_rst_pass", pass_cnt, '0);
    check("t5_rst_drop", drop_cnt, '0);
    drive(mk(MID, 16'hFF01, PTP, 3), 1'b1);
    drive(mk(TAIL, 16'hFF01, PTP, 4), 1'b1);
    send(16'hFF01, NMAC_CFG, 4, 1'b1);
    gap(2);
    check("t5_pass", pass_cnt, 16'd1);
    check("t5_drop", drop_cnt, 16'd0);

    // T6: drop counter saturates on the 4-bit instance
    do_reset();
    for (int f = 0; f < 17; f++) send(16'h0800, PTP, 2, 1'b0);
    gap(2);
    check("t6_drop16", drop_cnt, 16'd17);
    check("t6_drop_sat", sat_drop, 4'hF);
    check("t6_pass_sat", sat_pass, 4'h0);

    gap(2);
    check("final_q_empty", 134'(exp_q.size()), '0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
